inst_loader: RTL and testbench
==============================

Name: inst_loader

Overview:
Boot-time writer for the instruction memory that the core fetches from. Accepts a framed byte stream (length, payload, checksum) over a valid/ready interface and assembles little-endian 32-bit words. Writes each word into instruction memory at consecutive word addresses. Holds the core in reset until a load completes with a correct checksum.

Parameters:
ADDR_W, 10, instruction memory word-address width (matches core pc width)
MAX_WORDS, 1024, largest accepted word count (at most 2**ADDR_W)
TIMEOUT_CYC, 65535, idle cycles without an accepted byte before a load aborts

Ports:
clk  input  1  system clock, all state on rising edge
rstn  input  1  asynchronous active-low reset
start  input  1  single-cycle request to begin a load
s_valid  input  1  byte stream valid
s_data  input  8  byte stream data
s_ready  output  1  loader can accept a byte this cycle
im_w_en  output  1  instruction memory write strobe, one cycle per word
im_w_addr  output  ADDR_W  instruction memory word address
im_w_data  output  32  instruction word
core_rstn  output  1  active-low reset to core; high only after a successful load
busy  output  1  a load is in progress
done  output  1  last load succeeded
err  output  1  last load failed
words_loaded  output  ADDR_W+1  words written in the current or last load

Behaviour:
- Reset (async, rstn low):
  - state=IDLE.
  - All outputs 0, including core_rstn=0.
  - Word counter, byte lane, checksum and timeout counter cleared.
  - Memory contents are not cleared.
- Frame format: LEN0, LEN1 (word count N = {LEN1,LEN0}, little-endian), then 4*N payload bytes (LSB first per word), then one CHK byte. CHK must equal the XOR of every preceding frame byte, including LEN0 and LEN1.
- States: IDLE, LEN0, LEN1, DATA, CHK, DONE, ERR.
- Byte acceptance:
  - A byte is accepted when s_valid & s_ready.
  - s_ready=1 exactly in LEN0, LEN1, DATA and CHK.
  - busy=1 in the same states.
- Start:
  - start in IDLE, DONE or ERR moves to LEN0 next cycle.
  - On that edge, clear done, err, words_loaded, checksum and counters, and drive core_rstn to 0.
  - start in any other state is ignored.
- LEN1 accept: if N==0 or N>MAX_WORDS, go to ERR; otherwise go to DATA.
- DATA:
  - Each accepted byte fills lane 0..3 of the assembly register.
  - On acceptance of lane 3, the next cycle has im_w_en=1, im_w_addr=word index (starting at 0) and im_w_data=the assembled word. This is a registered, 1-cycle latency write.
  - The word index and words_loaded increment with that write.
  - After word N-1 is accepted, go to CHK. The final write strobe overlaps the first CHK cycle, which is legal.
- im_w_en is never high outside that single cycle. im_w_addr/im_w_data hold their last values when im_w_en=0.
- CHK accept: match goes to DONE, mismatch goes to ERR.
- DONE: done=1, core_rstn=1 from the cycle after entry, both registered. The loader stays in DONE until start.
- ERR: err=1, core_rstn=0. The loader stays in ERR until start.
- Timeout:
  - In LEN0..CHK, the idle counter increments each cycle with no accepted byte and clears on each accept.
  - When it reaches TIMEOUT_CYC, go to ERR.
  - A byte accepted in the same cycle takes priority and clears the counter.
- Address wrap is impossible because N≤MAX_WORDS. The word index saturates and never wraps.
- Reset asserted mid-load: immediate return to reset values. Already-written words remain in memory; the core stays in reset.

Test Plan:
- Good load, no gaps. After reset, pulse start, then stream 02 00 93 00 50 00 13 01 10 00 C3.
  - Writes: addr0=0x00500093, addr1=0x00100113, each im_w_en exactly 1 cycle.
  - Then done=1, core_rstn=1, words_loaded=2, err=0.
- Same stream with s_valid deasserted randomly for 1–5 cycles between bytes. Writes and final status identical; no write occurs on a non-accepted cycle.
- Same stream but CHK=0xC2. Both writes still occur; err=1, done=0, core_rstn stays 0.
- Length edge cases:
  - LEN 00 00 gives ERR after LEN1, with no writes.
  - LEN 01 04 (N=1025) gives ERR, with no writes.
  - LEN 00 04 (N=1024) is accepted, and the last write is to addr 1023.
- Timeout (TIMEOUT_CYC=16 in bench): stop after 5 payload bytes. ERR follows 16 idle cycles later, words_loaded=1, s_ready=0.
- Restart from DONE:
  - Pulse start and core_rstn drops to 0 the next cycle.
  - Reload one word (01 00 + 4 bytes + correct CHK) to addr0; done returns with words_loaded=1.
  - Asserting rstn low mid-payload returns all outputs to 0.

Source files
------------

// File: rtl/inst_loader.sv
// Boot loader: receives a length/payload/checksum byte frame, assembles little-endian
// 32-bit words into instruction memory and releases the core only after a clean load.
module inst_loader #(
  parameter int ADDR_W      = 10,
  parameter int MAX_WORDS   = 1024,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic              s_valid,
  input  logic [7:0]        s_data,
  output logic              s_ready,
  output logic              im_w_en,
  output logic [ADDR_W-1:0] im_w_addr,
  output logic [31:0]       im_w_data,
  output logic              core_rstn,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   words_loaded
);

  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {IDLE, LEN0, LEN1, DATA, CHK, DONE, ERR} state_t;

  state_t              state_reg, state_next;
  logic [7:0]          len0_reg;
  logic [15:0]         len_reg;
  logic [1:0]          lane_reg;
  logic [23:0]         asm_reg;
  logic [7:0]          csum_reg;
  logic [TO_W-1:0]     idle_reg;
  logic [ADDR_W:0]     word_cnt_reg;
  logic                im_w_en_reg;
  logic [ADDR_W-1:0]   im_w_addr_reg;
  logic [31:0]         im_w_data_reg;
  logic                done_reg;
  logic                err_reg;
  logic                core_rstn_reg;

  logic                active;
  logic                accept;
  logic                start_ok;
  logic                timeout_hit;
  logic                len_bad;
  logic                last_word;
  logic [15:0]         len_in;
  logic [ADDR_W:0]     word_cnt_inc;

  always_comb begin
    active       = (state_reg == LEN0) || (state_reg == LEN1) ||
                   (state_reg == DATA) || (state_reg == CHK);
    accept       = active && s_valid;
    start_ok     = start && ((state_reg == IDLE) || (state_reg == DONE) || (state_reg == ERR));
    // An accepted byte in the same cycle always wins over the timeout
    timeout_hit  = active && !s_valid && (idle_reg == TO_W'(TIMEOUT_CYC - 1));
    len_in       = {s_data, len0_reg};
    len_bad      = (len_in == 16'd0) || (32'(len_in) > MAX_WORDS);
    word_cnt_inc = word_cnt_reg + {{ADDR_W{1'b0}}, 1'b1};
    last_word    = (lane_reg == 2'd3) && (32'(word_cnt_inc) == 32'(len_reg));
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE, DONE, ERR: if (start) state_next = LEN0;
      LEN0:            if (accept) state_next = LEN1;
                       else if (timeout_hit) state_next = ERR;
      LEN1:            if (accept) state_next = len_bad ? ERR : DATA;
                       else if (timeout_hit) state_next = ERR;
      DATA:            if (accept && last_word) state_next = CHK;
                       else if (timeout_hit) state_next = ERR;
      CHK:             if (accept) state_next = (s_data == csum_reg) ? DONE : ERR;
                       else if (timeout_hit) state_next = ERR;
      default:         state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      len0_reg      <= '0;
      len_reg       <= '0;
      lane_reg      <= '0;
      asm_reg       <= '0;
      csum_reg      <= '0;
      idle_reg      <= '0;
      word_cnt_reg  <= '0;
      im_w_en_reg   <= 1'b0;
      im_w_addr_reg <= '0;
      im_w_data_reg <= '0;
      done_reg      <= 1'b0;
      err_reg       <= 1'b0;
      core_rstn_reg <= 1'b0;
    end else begin
      im_w_en_reg <= 1'b0;
      if (start_ok) begin
        done_reg      <= 1'b0;
        err_reg       <= 1'b0;
        core_rstn_reg <= 1'b0;
        word_cnt_reg  <= '0;
        csum_reg      <= '0;
        idle_reg      <= '0;
        lane_reg      <= '0;
      end
      if (active) idle_reg <= accept ? '0 : idle_reg + TO_W'(1);
      if (accept) begin
        csum_reg <= csum_reg ^ s_data;
        case (state_reg)
          LEN0: len0_reg <= s_data;
          LEN1: len_reg  <= len_in;
          DATA: begin
            lane_reg <= lane_reg + 2'd1;
            if (lane_reg != 2'd3) begin
              asm_reg[8*lane_reg +: 8] <= s_data;
            end else begin
              // Word complete: registered write, counter saturates at MAX_WORDS
              im_w_en_reg   <= 1'b1;
              im_w_addr_reg <= word_cnt_reg[ADDR_W-1:0];
              im_w_data_reg <= {s_data, asm_reg};
              if (32'(word_cnt_reg) < MAX_WORDS) word_cnt_reg <= word_cnt_inc;
            end
          end
          default: ;
        endcase
      end
      if ((state_reg == CHK) && (state_next == DONE)) begin
        done_reg      <= 1'b1;
        core_rstn_reg <= 1'b1;
      end
      if ((state_reg != ERR) && (state_next == ERR)) begin
        err_reg       <= 1'b1;
        core_rstn_reg <= 1'b0;
      end
    end
  end

  assign s_ready      = active;
  assign busy         = active;
  assign im_w_en      = im_w_en_reg;
  assign im_w_addr    = im_w_addr_reg;
  assign im_w_data    = im_w_data_reg;
  assign core_rstn    = core_rstn_reg;
  assign done         = done_reg;
  assign err          = err_reg;
  assign words_loaded = word_cnt_reg;

endmodule

// File: tb/tb_inst_loader.sv
// Scoreboarded bench for inst_loader: directed frames, expected writes queued at
// stimulus time and popped by an independent write monitor.
module tb_inst_loader;
  localparam int ADDR_W = 10;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic              start = 1'b0;
  logic              s_valid = 1'b0;
  logic [7:0]        s_data = 8'h00;
  logic              s_ready;
  logic              im_w_en;
  logic [ADDR_W-1:0] im_w_addr;
  logic [31:0]       im_w_data;
  logic              core_rstn;
  logic              busy;
  logic              done;
  logic              err;
  logic [ADDR_W:0]   words_loaded;

  int checks = 0;
  int failures = 0;
  logic [41:0] exp_q[$];
  logic [7:0]  frame[$];
  int          last_addr = -1;

  inst_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(1024), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .rstn(rstn), .start(start), .s_valid(s_valid), .s_data(s_data),
    .s_ready(s_ready), .im_w_en(im_w_en), .im_w_addr(im_w_addr), .im_w_data(im_w_data),
    .core_rstn(core_rstn), .busy(busy), .done(done), .err(err), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end else begin
      $display("ok   %s = %h", name, act);
    end
  endtask

  // Write monitor: every strobe must match the oldest queued write
  always @(negedge clk) begin
    logic [41:0] e;
    if (rstn && im_w_en) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write addr=%0d data=%h expected=none", im_w_addr, im_w_data);
      end else begin
        e = exp_q.pop_front();
        checks++;
        if (im_w_addr !== e[41:32] || im_w_data !== e[31:0]) begin
          failures++;
          $display("FAIL write actual=%0d:%h expected=%0d:%h", im_w_addr, im_w_data, e[41:32], e[31:0]);
        end
        last_addr = int'(im_w_addr);
      end
    end
  end

  task automatic push_word(input int addr, input logic [31:0] data);
    exp_q.push_back({10'(addr), data});
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    logic acc;
    int   n;
    s_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    s_valid = 1'b1;
    s_data  = b;
    n = 0;
    acc = 1'b0;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = s_ready;
      @(posedge clk); #1;
      n++;
    end
    if (!acc) begin
      checks++;
      failures++;
      $display("FAIL byte_accept actual=stalled expected=accepted byte=%h", b);
    end
    s_valid = 1'b0;
  endtask

  task automatic send_frame(input int maxgap);
    foreach (frame[i]) send_byte(frame[i], (maxgap == 0) ? 0 : int'($urandom_range(1, maxgap)));
  endtask

  task automatic wait_end();
    int n = 0;
    while (!(done || err) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!(done || err)) begin
      checks++;
      failures++;
      $display("FAIL load_end actual=no_status expected=done_or_err");
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic check_status(input string tag, input logic d, input logic e,
                              input logic cr, input int wl);
    chk({tag, "_done"}, 64'(done), 64'(d));
    chk({tag, "_err"}, 64'(err), 64'(e));
    chk({tag, "_core_rstn"}, 64'(core_rstn), 64'(cr));
    chk({tag, "_words"}, 64'(words_loaded), 64'(wl));
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_pending_writes"}, 64'(exp_q.size()), 64'd0);
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({s_ready, im_w_en, im_w_addr, im_w_data, core_rstn, busy, done, err, words_loaded});
  endfunction

  initial begin
    logic [31:0] w;
    logic [7:0]  cs;
    int          n;

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_outputs", all_outs(), 64'd0);
    @(posedge clk); #1;
    rstn = 1'b1;

    // Good load, no gaps
    push_word(0, 32'h00500093);
    push_word(1, 32'h00100113);
    frame = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'h10, 8'h00, 8'hC3};
    pulse_start();
    send_frame(0);
    wait_end();
    check_status("good", 1'b1, 1'b0, 1'b1, 2);

    // Restart from DONE drops core reset next cycle; gapped stream
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("restart_core_rstn", 64'(core_rstn), 64'd0);
    chk("restart_done", 64'(done), 64'd0);
    chk("restart_busy", 64'(busy), 64'd1);
    push_word(0, 32'h00500093);
    push_word(1, 32'h00100113);
    send_frame(5);
    wait_end();
    check_status("gaps", 1'b1, 1'b0, 1'b1, 2);

    // Bad checksum: writes still happen
    push_word(0, 32'h00500093);
    push_word(1, 32'h00100113);
    frame[10] = 8'hC2;
    pulse_start();
    send_frame(0);
    wait_end();
    check_status("badchk", 1'b0, 1'b1, 1'b0, 2);

    // Zero length
    frame = '{8'h00, 8'h00};
    pulse_start();
    send_frame(0);
    wait_end();
    check_status("len0", 1'b0, 1'b1, 1'b0, 0);

    // Length 1025 rejected
    frame = '{8'h01, 8'h04};
    pulse_start();
    send_frame(0);
    wait_end();
    check_status("len1025", 1'b0, 1'b1, 1'b0, 0);

    // Length 1024 accepted, last write to 1023
    frame = '{8'h00, 8'h04};
    cs = 8'h04;
    for (int i = 0; i < 1024; i++) begin
      w = 32'h0F00_0000 ^ (32'(i) * 32'h0001_0203);
      push_word(i, w);
      for (int b = 0; b < 4; b++) begin
        frame.push_back(w[8*b +: 8]);
        cs = cs ^ w[8*b +: 8];
      end
    end
    frame.push_back(cs);
    pulse_start();
    send_frame(0);
    wait_end();
    check_status("len1024", 1'b1, 1'b0, 1'b1, 1024);
    chk("len1024_last_addr", 64'(last_addr), 64'd1023);

    // Timeout after 5 payload bytes
    push_word(0, 32'h00500093);
    frame = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13};
    pulse_start();
    send_frame(0);
    n = 0;
    while (!err && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("timeout_cycles", 64'(n), 64'd17);
    chk("timeout_s_ready", 64'(s_ready), 64'd0);
    check_status("timeout", 1'b0, 1'b1, 1'b0, 1);

    // Reload one word from ERR, then again from DONE
    frame = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h23};
    push_word(0, 32'hDEADBEEF);
    pulse_start();
    send_frame(2);
    wait_end();
    check_status("reload_err", 1'b1, 1'b0, 1'b1, 1);
    push_word(0, 32'hDEADBEEF);
    pulse_start();
    @(negedge clk);
    chk("reload_core_rstn", 64'(core_rstn), 64'd0);
    @(posedge clk); #1;
    send_frame(0);
    wait_end();
    check_status("reload_done", 1'b1, 1'b0, 1'b1, 1);

    // Reset mid-payload
    frame = '{8'h01, 8'h00, 8'hEF, 8'hBE};
    pulse_start();
    send_frame(0);
    rstn = 1'b0;
    #1;
    chk("midreset_async", all_outs(), 64'd0);
    @(negedge clk);
    chk("midreset_outputs", all_outs(), 64'd0);
    @(posedge clk); #1;
    rstn = 1'b1;
    repeat (3) @(negedge clk);
    chk("midreset_no_writes", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "bench time limit");
  end
endmodule
